// File: rtl/ff_apb_gpio.sv
`default_nettype none
// ============================================================================
// Module   : ff_apb_gpio
// Purpose  : APB zero-wait-state GPIO controller with per-bit direction,
//            atomic output set/clear, multi-stage input synchroniser and
//            per-bit rising/falling edge capture with a maskable interrupt.
// Ports    : clk, reset         - clock, synchronous active-high reset
//            paddr/psel/penable/pwrite/pwdata/prdata - APB slave port
//            gpio_in            - asynchronous pad inputs
//            gpio_out, gpio_oe  - output data / output enable to pad ring
//            irq                - level interrupt |(IRQ_STATUS & IRQ_MASK)
// Revision : 1.0 - initial release
// ============================================================================
module ff_apb_gpio #(
    parameter int GPIO_WIDTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [19:0]           paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [31:0]           pwdata,
    output logic [31:0]           prdata,
    input  logic [GPIO_WIDTH-1:0] gpio_in,
    output logic [GPIO_WIDTH-1:0] gpio_out,
    output logic [GPIO_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    // Register word offsets (paddr[5:2])
    localparam logic [3:0] c_addr_data_in  = 4'h0;
    localparam logic [3:0] c_addr_data_out = 4'h1;
    localparam logic [3:0] c_addr_dir      = 4'h2;
    localparam logic [3:0] c_addr_out_set  = 4'h3;
    localparam logic [3:0] c_addr_out_clr  = 4'h4;
    localparam logic [3:0] c_addr_rise_en  = 4'h5;
    localparam logic [3:0] c_addr_fall_en  = 4'h6;
    localparam logic [3:0] c_addr_irq_mask = 4'h7;
    localparam logic [3:0] c_addr_irq_stat = 4'h8;

    logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] r_sync;
    logic [GPIO_WIDTH-1:0] r_prev;
    logic [GPIO_WIDTH-1:0] r_data_out;
    logic [GPIO_WIDTH-1:0] r_dir;
    logic [GPIO_WIDTH-1:0] r_rise_en;
    logic [GPIO_WIDTH-1:0] r_fall_en;
    logic [GPIO_WIDTH-1:0] r_irq_mask;
    logic [GPIO_WIDTH-1:0] r_irq_status;
    logic [31:0]           r_prdata;

    logic [GPIO_WIDTH-1:0] w_sync;
    logic [GPIO_WIDTH-1:0] w_wdata;
    logic [GPIO_WIDTH-1:0] w_edge_set;
    logic [GPIO_WIDTH-1:0] w_w1c;
    logic [GPIO_WIDTH-1:0] w_rdata;
    logic [3:0]            w_addr;
    logic                  w_wr_access;
    logic                  w_rd_setup;
    logic                  w_unused_bits;

    assign w_addr      = paddr[5:2];
    assign w_wdata     = pwdata[GPIO_WIDTH-1:0];
    assign w_wr_access = psel & penable & pwrite;
    // Read data is captured in the setup phase so it is stable for the
    // whole access phase without needing a combinational read path.
    assign w_rd_setup  = psel & ~penable & ~pwrite;

    // Address bits outside [5:2] and data bits above GPIO_WIDTH are
    // deliberately ignored.
    assign w_unused_bits = ^{paddr[19:6], paddr[1:0], pwdata};

    // Oldest synchroniser stage is the one the rest of the design sees.
    assign w_sync = r_sync[SYNC_STAGES-1];

    assign w_edge_set = (w_sync & ~r_prev & r_rise_en)
                      | (~w_sync & r_prev & r_fall_en);

    always_comb begin
        w_w1c = '0;
        if (w_wr_access && (w_addr == c_addr_irq_stat)) begin
            w_w1c = w_wdata;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_addr)
            c_addr_data_in:  w_rdata = w_sync;
            c_addr_data_out: w_rdata = r_data_out;
            c_addr_dir:      w_rdata = r_dir;
            c_addr_rise_en:  w_rdata = r_rise_en;
            c_addr_fall_en:  w_rdata = r_fall_en;
            c_addr_irq_mask: w_rdata = r_irq_mask;
            c_addr_irq_stat: w_rdata = r_irq_status;
            default:         w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync       <= '0;
            r_prev       <= '0;
            r_data_out   <= '0;
            r_dir        <= '0;
            r_rise_en    <= '0;
            r_fall_en    <= '0;
            r_irq_mask   <= '0;
            r_irq_status <= '0;
            r_prdata     <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_in};
            r_prev <= w_sync;

            // OR-ing the new edges after the clear makes a same-cycle edge
            // win over a W1C of that bit.
            r_irq_status <= (r_irq_status & ~w_w1c) | w_edge_set;

            if (w_rd_setup) begin
                r_prdata <= 32'(w_rdata);
            end

            if (w_wr_access) begin
                case (w_addr)
                    c_addr_data_out: r_data_out <= w_wdata;
                    c_addr_dir:      r_dir      <= w_wdata;
                    c_addr_out_set:  r_data_out <= r_data_out | w_wdata;
                    c_addr_out_clr:  r_data_out <= r_data_out & ~w_wdata;
                    c_addr_rise_en:  r_rise_en  <= w_wdata;
                    c_addr_fall_en:  r_fall_en  <= w_wdata;
                    c_addr_irq_mask: r_irq_mask <= w_wdata;
                    default: ;
                endcase
            end
        end
    end

    assign prdata   = r_prdata;
    assign gpio_out = r_data_out;
    assign gpio_oe  = r_dir;
    assign irq      = |(r_irq_status & r_irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_ff_apb_gpio.sv
`default_nettype none
// ============================================================================
// Module   : tb_ff_apb_gpio
// Purpose  : Self-checking bench for ff_apb_gpio: directed feature tests plus
//            randomized bus/pad traffic against a register-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ff_apb_gpio;

    localparam int GPIO_WIDTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam logic [31:0] MASK = 32'((64'd1 << GPIO_WIDTH) - 64'd1);

    logic                  clk;
    logic                  reset;
    logic [19:0]           paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [31:0]           pwdata;
    logic [31:0]           prdata;
    logic [GPIO_WIDTH-1:0] pad;
    logic [GPIO_WIDTH-1:0] gpio_out;
    logic [GPIO_WIDTH-1:0] gpio_oe;
    logic                  irq;

    int n_checks;
    int n_fail;

    ff_apb_gpio #(
        .GPIO_WIDTH  (GPIO_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .gpio_in  (pad),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: register file as plain variables, the synchroniser
    // as a queue of the last SYNC_STAGES pad samples.
    // ------------------------------------------------------------------
    logic [31:0] m_dout, m_dir, m_rise, m_fall, m_mask, m_stat;
    logic [31:0] m_sync, m_prev, m_prdata;
    logic [31:0] m_hist[$];
    wire         m_irq = |(m_stat & m_mask);

    function automatic logic [31:0] model_read(input int idx);
        case (idx)
            0:       return m_sync;
            1:       return m_dout;
            2:       return m_dir;
            5:       return m_rise;
            6:       return m_fall;
            7:       return m_mask;
            8:       return m_stat;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin : p_model
        logic [31:0] edges;
        logic [31:0] wd;
        int          idx;
        if (reset) begin
            m_dout = 0; m_dir = 0; m_rise = 0; m_fall = 0; m_mask = 0;
            m_stat = 0; m_sync = 0; m_prev = 0; m_prdata = 0;
            m_hist = {};
            for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(32'h0);
        end else begin
            idx = int'(paddr[5:2]);
            wd  = pwdata & MASK;
            if (psel && !penable && !pwrite) m_prdata = model_read(idx);
            edges = (m_sync & ~m_prev & m_rise) | (~m_sync & m_prev & m_fall);
            if (psel && penable && pwrite) begin
                case (idx)
                    1: m_dout = wd;
                    2: m_dir  = wd;
                    3: m_dout = m_dout | wd;
                    4: m_dout = m_dout & ~wd;
                    5: m_rise = wd;
                    6: m_fall = wd;
                    7: m_mask = wd;
                    8: m_stat = m_stat & ~wd;
                    default: ;
                endcase
            end
            m_stat = m_stat | edges;
            m_prev = m_sync;
            m_hist.push_back(32'(pad) & MASK);
            void'(m_hist.pop_front());
            m_sync = m_hist[0];
        end
    end

    // ------------------------------------------------------------------
    // Bus drivers (called #1 after a rising edge; return #1 after one)
    // ------------------------------------------------------------------
    task automatic apb_write(input logic [19:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [19:0] a, output logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1 penable = 1'b1; d = prdata;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pad = '0;
        tick(SYNC_STAGES + 2);
        reset = 1'b0;
        n_checks++;
        if ({gpio_out, gpio_oe, irq, prdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got out=%h oe=%h irq=%b prdata=%h, expected all 0",
                     gpio_out, gpio_oe, irq, prdata);
        end
        for (int i = 0; i < 12; i++) begin
            apb_read(20'(i * 4), d);
            n_checks++;
            if (d !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_read[%0h]: got %h expected 0", i * 4, d);
            end
        end
    endtask

    task automatic test_outputs();
        logic [31:0] d;
        apb_write(20'h08, 32'hF);
        apb_write(20'h04, 32'h5);
        n_checks++;
        if ({gpio_oe, gpio_out} !== {4'hF, 4'h5}) begin
            n_fail++;
            $display("FAIL out_write: got oe=%h out=%h expected oe=f out=5", gpio_oe, gpio_out);
        end
        apb_write(20'h0C, 32'h2);
        n_checks++;
        if (gpio_out !== 4'h7) begin
            n_fail++;
            $display("FAIL out_set: got %h expected 7", gpio_out);
        end
        apb_write(20'h10, 32'h4);
        n_checks++;
        if (gpio_out !== 4'h3) begin
            n_fail++;
            $display("FAIL out_clr: got %h expected 3", gpio_out);
        end
        apb_read(20'h04, d);
        n_checks++;
        if (d !== 32'h3) begin
            n_fail++;
            $display("FAIL read_data_out: got %h expected 3", d);
        end
        apb_read(20'h0C, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL read_out_set: got %h expected 0", d);
        end
        apb_write(20'h04, 32'hFFFF_FFFF);
        apb_read(20'h04, d);
        n_checks++;
        if (d !== MASK) begin
            n_fail++;
            $display("FAIL width_mask: got %h expected %h", d, MASK);
        end
    endtask

    task automatic test_rise_irq();
        logic [31:0] d;
        apb_write(20'h14, 32'h1);
        apb_write(20'h1C, 32'h1);
        pad[0] = 1'b1;
        tick(SYNC_STAGES);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_early: got irq=%b expected 0 after %0d edges", irq, SYNC_STAGES);
        end
        tick(1);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL rise_irq: got irq=%b expected 1 after %0d edges", irq, SYNC_STAGES + 1);
        end
        apb_read(20'h20, d);
        n_checks++;
        if (d !== 32'h1) begin
            n_fail++;
            $display("FAIL rise_status: got %h expected 1", d);
        end
        apb_write(20'h20, 32'h1);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL w1c_irq: got irq=%b expected 0", irq);
        end
        pad[0] = 1'b0;
        tick(SYNC_STAGES + 2);
        apb_read(20'h20, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL fall_no_rise: got %h expected 0", d);
        end
    endtask

    task automatic test_fall_mask();
        logic [31:0] d;
        apb_write(20'h18, 32'h2);
        apb_write(20'h1C, 32'h0);
        pad[1] = 1'b1;
        tick(SYNC_STAGES + 2);
        pad[1] = 1'b0;
        tick(SYNC_STAGES + 2);
        apb_read(20'h20, d);
        n_checks++;
        if ({d, irq} !== {32'h2, 1'b0}) begin
            n_fail++;
            $display("FAIL fall_masked: got status=%h irq=%b expected 2/0", d, irq);
        end
        apb_write(20'h1C, 32'h2);
        n_checks++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL unmask_irq: got irq=%b expected 1", irq);
        end
        apb_write(20'h20, 32'h2);
        apb_write(20'h18, 32'h0);
        apb_write(20'h1C, 32'h0);
    endtask

    task automatic test_collision();
        logic [31:0] d;
        apb_write(20'h14, 32'h1);
        apb_write(20'h1C, 32'h1);
        pad[0] = 1'b1;
        tick(SYNC_STAGES + 2);
        pad[0] = 1'b0;
        tick(SYNC_STAGES + 2);
        apb_read(20'h20, d);
        n_checks++;
        if (d !== 32'h1) begin
            n_fail++;
            $display("FAIL collide_pre: got %h expected 1", d);
        end
        // Time the W1C so its access edge is the edge that captures the rise.
        pad[0] = 1'b1;
        tick(SYNC_STAGES - 1);
        apb_write(20'h20, 32'h1);
        apb_read(20'h20, d);
        n_checks++;
        if ({d, irq} !== {32'h1, 1'b1}) begin
            n_fail++;
            $display("FAIL collide_set_wins: got status=%h irq=%b expected 1/1", d, irq);
        end
        apb_write(20'h20, 32'h1);
        apb_read(20'h20, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL collide_clear: got %h expected 0", d);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h08; pwdata = 32'hF;
        @(posedge clk); #1 penable = 1'b1; reset = 1'b1;
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0; reset = 1'b0;
        apb_read(20'h08, d);
        n_checks++;
        if ({d, gpio_oe, gpio_out} !== {32'h0, 4'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL reset_mid_write: got dir=%h oe=%h out=%h expected 0", d, gpio_oe, gpio_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got[3];
        logic [31:0] d1, d2, d3;
        int          ri;
        logic        wr[7]  = '{1, 0, 1, 0, 1, 0, 0};
        logic [19:0] ad[7]  = '{20'h04, 20'h04, 20'h08, 20'h08, 20'h0C, 20'h04, 20'h08};
        logic [31:0] dat[7];
        d1 = $urandom; d2 = $urandom; d3 = $urandom;
        dat = '{d1, 0, d2, 0, d3, 0, 0};
        ri  = 0;
        for (int i = 0; i < 7; i++) begin
            psel = 1'b1; penable = 1'b0; pwrite = wr[i]; paddr = ad[i]; pwdata = dat[i];
            @(posedge clk); #1 penable = 1'b1;
            if (!wr[i] && i >= 3) begin
                got[ri] = prdata;
                ri++;
            end else if (!wr[i]) begin
                n_checks++;
                if (prdata !== (d1 & MASK)) begin
                    n_fail++;
                    $display("FAIL b2b_read_dout: got %h expected %h", prdata, d1 & MASK);
                end
            end
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        n_checks++;
        if (got[0] !== (d2 & MASK)) begin
            n_fail++;
            $display("FAIL b2b_read_dir: got %h expected %h", got[0], d2 & MASK);
        end
        n_checks++;
        if ({got[1], got[2]} !== {((d1 | d3) & MASK), (d2 & MASK)}) begin
            n_fail++;
            $display("FAIL b2b_read_set: got %h/%h expected %h/%h",
                     got[1], got[2], (d1 | d3) & MASK, d2 & MASK);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [19:0] a;
        int          op;
        int          idx;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 2) == 0) pad = GPIO_WIDTH'($urandom);
            op = $urandom_range(0, 3);
            if (op == 0) begin
                tick(1);
            end else if (op == 1) begin
                idx = $urandom_range(0, 9);
                a = {14'($urandom), 4'(idx), 2'($urandom)};
                apb_write(a, $urandom);
            end else begin
                idx = $urandom_range(0, 11);
                a = {14'($urandom), 4'(idx), 2'($urandom)};
                apb_read(a, d);
                n_checks++;
                if (d !== m_prdata) begin
                    n_fail++;
                    $display("FAIL rand_read[%0h]: got %h expected %h", idx * 4, d, m_prdata);
                end
            end
            n_checks++;
            if ({gpio_out, gpio_oe, irq} !==
                {m_dout[GPIO_WIDTH-1:0], m_dir[GPIO_WIDTH-1:0], m_irq}) begin
                n_fail++;
                $display("FAIL rand_outputs: got out=%h oe=%h irq=%b expected out=%h oe=%h irq=%b",
                         gpio_out, gpio_oe, irq,
                         m_dout[GPIO_WIDTH-1:0], m_dir[GPIO_WIDTH-1:0], m_irq);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_outputs();
        test_rise_irq();
        test_fall_mask();
        test_collision();
        test_reset_mid_write();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
